// File: rtl/monster_chaser.sv
`default_nettype none
// ============================================================================
//  Module      : monster_chaser
//  Description : Moves one monster tile by tile toward the player, probing the
//                map for walkability through dest_r/dest_c -> dest_type, and
//                tracks the monster's hit points.
//                Optional feature macro: MONSTER_RESPAWN_EN (timed respawn
//                after death; without it DEAD is terminal until rst).
//  Revision    : 1.0 - initial release
// ============================================================================
module monster_chaser #(
    parameter int START_R       = 3,
    parameter int START_C       = 8,
    parameter int STEP_PERIOD   = 4096,
    parameter int HP_FULL       = 3,
    parameter int RESPAWN_DELAY = 65535
) (
    input  logic       clk_13,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] player_r,
    input  logic [9:0] player_c,
    input  logic       player_alive,
    input  logic       hit,
    input  logic [2:0] dest_type,
    output logic [9:0] dest_r,
    output logic [9:0] dest_c,
    output logic [9:0] monster_r,
    output logic [9:0] monster_c,
    output logic [4:0] monster_hp,
    output logic       monster_alive
);

    localparam int              SCW        = $clog2(STEP_PERIOD);
    localparam logic [SCW-1:0]  STEP_LAST  = SCW'(STEP_PERIOD - 1);
    localparam logic [9:0]      SPAWN_R    = 10'(START_R);
    localparam logic [9:0]      SPAWN_C    = 10'(START_C);
    localparam logic [4:0]      HP_INIT    = 5'(HP_FULL);

    // Direction codes shared with the player block
    localparam logic [2:0] DIR_STOP  = 3'd0;
    localparam logic [2:0] DIR_DOWN  = 3'd1;
    localparam logic [2:0] DIR_UP    = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROBE_A = 2'd1,
        PROBE_B = 2'd2,
        DEAD    = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [SCW-1:0] step_cnt;
    logic [2:0]     last_dir;
    // Candidate layout: {valid, row[9:0], col[9:0]}
    logic [20:0]    cand_a, cand_b;
    logic [2:0]     cand_a_dir, cand_b_dir;

    logic [10:0]    dr, dc, abs_dr, abs_dc;
    logic [2:0]     dir_a, dir_b;
    logic [20:0]    next_a, next_b;
    logic           run, walkable, kill, hp_dec, step_go, commit;
    logic [9:0]     commit_r, commit_c;
    logic [2:0]     commit_dir;

    // One tile step in the given direction; invalid if it would leave the
    // 0..1023 range (no wrap) or if the direction is STOP (no candidate).
    function automatic logic [20:0] step_to(input logic [2:0] dir,
                                            input logic [9:0] r,
                                            input logic [9:0] c);
        logic [20:0] res;
        res = {1'b0, r, c};
        case (dir)
            DIR_DOWN:  if (r != 10'h3ff) res = {1'b1, r + 10'd1, c};
            DIR_UP:    if (r != 10'd0)   res = {1'b1, r - 10'd1, c};
            DIR_LEFT:  if (c != 10'd0)   res = {1'b1, r, c - 10'd1};
            DIR_RIGHT: if (c != 10'h3ff) res = {1'b1, r, c + 10'd1};
            default:   res = {1'b0, r, c};
        endcase
        return res;
    endfunction

    assign run           = enable & player_alive;
    assign walkable      = (dest_type == 3'b000) || (dest_type == 3'b001) ||
                           (dest_type == 3'b011);
    assign hp_dec        = hit && (state != DEAD) && (monster_hp != 5'd0);
    assign kill          = hp_dec && (monster_hp == 5'd1);
    assign monster_alive = (monster_hp != 5'd0);
    assign dr            = {1'b0, player_r} - {1'b0, monster_r};
    assign dc            = {1'b0, player_c} - {1'b0, monster_c};
    assign abs_dr        = dr[10] ? (11'd0 - dr) : dr;
    assign abs_dc        = dc[10] ? (11'd0 - dc) : dc;

    // Choose primary/secondary directions toward the player, or retreat
    always_comb begin
        dir_a = DIR_STOP;
        dir_b = DIR_STOP;
        if ((dr == 11'd0) && (dc == 11'd0)) begin
            case (last_dir)
                DIR_DOWN:  dir_a = DIR_UP;
                DIR_UP:    dir_a = DIR_DOWN;
                DIR_LEFT:  dir_a = DIR_RIGHT;
                DIR_RIGHT: dir_a = DIR_LEFT;
                default:   dir_a = DIR_UP;
            endcase
        end else if (abs_dr >= abs_dc) begin
            dir_a = dr[10] ? DIR_UP : DIR_DOWN;
            if (dc != 11'd0) dir_b = dc[10] ? DIR_LEFT : DIR_RIGHT;
        end else begin
            dir_a = dc[10] ? DIR_LEFT : DIR_RIGHT;
            if (dr != 11'd0) dir_b = dr[10] ? DIR_UP : DIR_DOWN;
        end
        next_a = step_to(dir_a, monster_r, monster_c);
        next_b = step_to(dir_b, monster_r, monster_c);
    end

`ifdef MONSTER_RESPAWN_EN
    localparam int             RCW          = $clog2(RESPAWN_DELAY + 1);
    localparam logic [RCW-1:0] RESPAWN_LAST = RCW'(RESPAWN_DELAY - 1);
    logic [RCW-1:0] dead_cnt;
    logic           respawn;
    assign respawn = (state == DEAD) && (dead_cnt == RESPAWN_LAST);
`else
    logic unused_respawn_delay;
    assign unused_respawn_delay = (RESPAWN_DELAY != 0);
`endif

    // FSM state register
    always_ff @(posedge clk_13 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, probe address and commit decision
    always_comb begin
        state_next = state;
        step_go    = 1'b0;
        commit     = 1'b0;
        commit_r   = monster_r;
        commit_c   = monster_c;
        commit_dir = last_dir;
        dest_r     = monster_r;
        dest_c     = monster_c;
        case (state)
            IDLE: begin
                if (run && (step_cnt == STEP_LAST)) begin
                    step_go    = 1'b1;
                    state_next = PROBE_A;
                end
            end
            PROBE_A: begin
                state_next = cand_b[20] ? PROBE_B : IDLE;
                if (cand_a[20]) begin
                    dest_r = cand_a[19:10];
                    dest_c = cand_a[9:0];
                    if (walkable) begin
                        commit     = 1'b1;
                        commit_r   = cand_a[19:10];
                        commit_c   = cand_a[9:0];
                        commit_dir = cand_a_dir;
                        state_next = IDLE;
                    end
                end
            end
            PROBE_B: begin
                state_next = IDLE;
                if (cand_b[20]) begin
                    dest_r = cand_b[19:10];
                    dest_c = cand_b[9:0];
                    if (walkable) begin
                        commit     = 1'b1;
                        commit_r   = cand_b[19:10];
                        commit_c   = cand_b[9:0];
                        commit_dir = cand_b_dir;
                    end
                end
            end
            DEAD: begin
`ifdef MONSTER_RESPAWN_EN
                if (respawn) state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
        // The killing hit wins over any move decided this cycle
        if (kill) begin
            state_next = DEAD;
            commit     = 1'b0;
            step_go    = 1'b0;
        end
    end

    // Position, hit points, step timer and latched candidates
    always_ff @(posedge clk_13 or posedge rst) begin
        if (rst) begin
            monster_r  <= SPAWN_R;
            monster_c  <= SPAWN_C;
            monster_hp <= HP_INIT;
            last_dir   <= DIR_STOP;
            step_cnt   <= '0;
            cand_a     <= '0;
            cand_b     <= '0;
            cand_a_dir <= DIR_STOP;
            cand_b_dir <= DIR_STOP;
`ifdef MONSTER_RESPAWN_EN
            dead_cnt   <= '0;
`endif
        end else begin
            if (hp_dec) monster_hp <= monster_hp - 5'd1;
            if (commit) begin
                monster_r <= commit_r;
                monster_c <= commit_c;
                last_dir  <= commit_dir;
            end
            if (step_go) begin
                step_cnt   <= '0;
                cand_a     <= next_a;
                cand_b     <= next_b;
                cand_a_dir <= dir_a;
                cand_b_dir <= dir_b;
            end else if ((state == IDLE) && run && !kill) begin
                step_cnt <= step_cnt + SCW'(1);
            end
`ifdef MONSTER_RESPAWN_EN
            if (state == DEAD) dead_cnt <= respawn ? '0 : dead_cnt + RCW'(1);
            if (respawn) begin
                monster_r  <= SPAWN_R;
                monster_c  <= SPAWN_C;
                monster_hp <= HP_INIT;
                last_dir   <= DIR_STOP;
                step_cnt   <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_monster_chaser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_monster_chaser
//  Description : Directed self-checking bench for monster_chaser with a
//                one-wall map model driving dest_type.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_monster_chaser;

    logic       clk_13 = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] player_r, player_c;
    logic       player_alive;
    logic       hit;
    logic [2:0] dest_type;
    logic [9:0] dest_r, dest_c, monster_r, monster_c;
    logic [4:0] monster_hp;
    logic       monster_alive;

    // Map model: one special tile, every other tile has open_type
    logic [9:0] wall_r, wall_c;
    logic [2:0] wall_type, open_type;

    int passed = 0;
    int total  = 0;

    monster_chaser #(
        .START_R       (3),
        .START_C       (8),
        .STEP_PERIOD   (4),
        .HP_FULL       (3),
        .RESPAWN_DELAY (10)
    ) dut (
        .clk_13        (clk_13),
        .rst           (rst),
        .enable        (enable),
        .player_r      (player_r),
        .player_c      (player_c),
        .player_alive  (player_alive),
        .hit           (hit),
        .dest_type     (dest_type),
        .dest_r        (dest_r),
        .dest_c        (dest_c),
        .monster_r     (monster_r),
        .monster_c     (monster_c),
        .monster_hp    (monster_hp),
        .monster_alive (monster_alive)
    );

    always #5 clk_13 = ~clk_13;

    always_comb begin
        dest_type = open_type;
        if ((dest_r == wall_r) && (dest_c == wall_c)) dest_type = wall_type;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_13);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        hit    = 1'b0;
        @(negedge clk_13);
        rst    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; hit = 1'b0; player_alive = 1'b1;
        player_r = 10'd3; player_c = 10'd3;
        wall_r = 10'd1023; wall_c = 10'd1023; wall_type = 3'b010; open_type = 3'b000;
        cycles(3);
        rst = 1'b0;

        // Reset values
        check("rst_monster_r", monster_r, 3);
        check("rst_monster_c", monster_c, 8);
        check("rst_hp", monster_hp, 3);
        check("rst_alive", monster_alive, 1);
        check("rst_dest_r", dest_r, 3);
        check("rst_dest_c", dest_c, 8);

        // enable low: no movement
        cycles(20000);
        check("idle_monster_r", monster_r, 3);
        check("idle_monster_c", monster_c, 8);

        // Open map, player (3,3): step left every 5 cycles
        enable = 1'b1;
        cycles(4);
        check("probe_a_dest_r", dest_r, 3);
        check("probe_a_dest_c", dest_c, 7);
        check("probe_a_no_move", monster_c, 8);
        cycles(1);
        check("move1_c", monster_c, 7);
        check("move1_r", monster_r, 3);
        cycles(5);
        check("move2_c", monster_c, 6);
        cycles(4);
        check("probe3_dest_c", dest_c, 5);
        // Asynchronous reset in the middle of a probe
        rst = 1'b1; enable = 1'b0;
        #1;
        check("async_rst_monster_c", monster_c, 8);
        check("async_rst_dest_c", dest_c, 8);
        check("async_rst_monster_r", monster_r, 3);
        @(negedge clk_13);
        rst = 1'b0;

        // Wall at (3,7), player (5,3): A blocked, B=(4,8) taken
        player_r = 10'd5; player_c = 10'd3;
        wall_r = 10'd3; wall_c = 10'd7; wall_type = 3'b010; open_type = 3'b001;
        enable = 1'b1;
        cycles(4);
        check("wall_probe_a_r", dest_r, 3);
        check("wall_probe_a_c", dest_c, 7);
        cycles(1);
        check("wall_probe_b_r", dest_r, 4);
        check("wall_probe_b_c", dest_c, 8);
        check("wall_hold_c", monster_c, 8);
        cycles(1);
        check("wall_move_r", monster_r, 4);
        check("wall_move_c", monster_c, 8);
        do_reset();

        // player_alive low freezes the timer; a blocked A with no B stays put
        player_r = 10'd3; player_c = 10'd3;
        wall_type = 3'b111; open_type = 3'b000;
        player_alive = 1'b0; enable = 1'b1;
        cycles(10);
        check("dead_player_dest_c", dest_c, 8);
        check("dead_player_monster_c", monster_c, 8);
        player_alive = 1'b1;
        cycles(4);
        check("blocked_probe_c", dest_c, 7);
        cycles(1);
        check("blocked_hold1_c", monster_c, 8);
        cycles(5);
        check("blocked_hold2_c", monster_c, 8);
        do_reset();

        // Tie rule and retreat, player (4,9), tiles of type 011
        player_r = 10'd4; player_c = 10'd9;
        wall_r = 10'd1023; wall_c = 10'd1023; open_type = 3'b011;
        enable = 1'b1;
        cycles(5);
        check("tie_down_r", monster_r, 4);
        check("tie_down_c", monster_c, 8);
        cycles(5);
        check("tie_right_r", monster_r, 4);
        check("tie_right_c", monster_c, 9);
        cycles(5);
        check("retreat_left_c", monster_c, 8);
        cycles(5);
        check("reenter_right_c", monster_c, 9);

        // Hits: 2, 1, then 0 during a PROBE_A that would move
        hit = 1'b1; cycles(1); hit = 1'b0;
        check("hit1_hp", monster_hp, 2);
        check("hit1_alive", monster_alive, 1);
        cycles(1); hit = 1'b1; cycles(1); hit = 1'b0;
        check("hit2_hp", monster_hp, 1);
        cycles(1);
        check("retreat_probe_c", dest_c, 8);
        check("pre_kill_alive", monster_alive, 1);
        hit = 1'b1; cycles(1); hit = 1'b0;
        check("hit3_hp", monster_hp, 0);
        check("hit3_alive", monster_alive, 0);
        check("abort_monster_c", monster_c, 9);
        check("abort_monster_r", monster_r, 4);
        check("dead_dest_c", dest_c, 9);
        cycles(1); hit = 1'b1; cycles(1); hit = 1'b0;
        check("hit_sat_hp", monster_hp, 0);

`ifdef MONSTER_RESPAWN_EN
        cycles(7);
        check("still_dead_hp", monster_hp, 0);
        cycles(1);
        check("respawn_r", monster_r, 3);
        check("respawn_c", monster_c, 8);
        check("respawn_hp", monster_hp, 3);
        check("respawn_alive", monster_alive, 1);
`else
        cycles(1000);
        check("terminal_hp", monster_hp, 0);
        check("terminal_alive", monster_alive, 0);
        check("terminal_c", monster_c, 9);
        check("terminal_dest_c", dest_c, 9);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
